// File: rtl/lcd_rx_model.sv
// lcd_rx_model: HD44780-style character LCD receiver with 128x8 DDRAM, busy timing,
// status/data readback, host inspection port and sticky protocol error flags.
module lcd_rx_model #(
    parameter int CLEAR_CYCLES = 160,
    parameter int OP_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_data_in,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       cmd_strobe,
    output logic       char_strobe,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       err_overrun,
    output logic       err_addr,
    input  logic       err_clr
);
    localparam int CMAX = (CLEAR_CYCLES > OP_CYCLES) ? CLEAR_CYCLES : OP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, OP, CLR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    sweep_q, sweep_d;
    logic          e_q;
    logic [6:0]    ac_q, ac_d;
    logic          disp_on_q, disp_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
    logic          entry_inc_q, entry_inc_d, entry_shift_q, entry_shift_d;
    logic          busy_q, busy_d;
    logic [7:0]    dout_q, dout_d;
    logic          oe_q, oe_d;
    logic          cmd_strobe_q, cmd_strobe_d, char_strobe_q, char_strobe_d;
    logic          err_overrun_q, err_overrun_d, err_addr_q, err_addr_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [7:0]    mem [128];
    logic          mem_we;
    logic [6:0]    mem_wa;
    logic [7:0]    mem_wd;
    logic          rise, fall, idle, wr_ok, rd_step, addr_ok;

    // Two visible lines: 0x00-0x27 and 0x40-0x67, wrapping into each other.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    assign rise    = lcd_e & ~e_q;
    assign fall    = ~lcd_e & e_q;
    assign idle    = state_q == IDLE;
    assign wr_ok   = fall & ~lcd_rw & idle;
    assign rd_step = fall & lcd_rw & lcd_rs & idle;
    assign addr_ok = lcd_data_in[6:0] <= 7'h27 ||
                     (lcd_data_in[6:0] >= 7'h40 && lcd_data_in[6:0] <= 7'h67);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CW'(1);
        sweep_d       = sweep_q;
        ac_d          = ac_q;
        disp_on_d     = disp_on_q;
        cursor_on_d   = cursor_on_q;
        blink_on_d    = blink_on_q;
        entry_inc_d   = entry_inc_q;
        entry_shift_d = entry_shift_q;
        mem_we        = 1'b0;
        mem_wa        = sweep_q[6:0];
        mem_wd        = 8'h20;
        cmd_strobe_d  = 1'b0;
        char_strobe_d = 1'b0;
        err_overrun_d = (fall & ~lcd_rw & ~idle) | (err_overrun_q & ~err_clr);
        err_addr_d    = (wr_ok & ~lcd_rs & lcd_data_in[7] & ~addr_ok) | (err_addr_q & ~err_clr);
        oe_d          = (rise & lcd_rw) | (oe_q & ~fall);
        dout_d        = (rise & lcd_rw) ? (lcd_rs ? mem[ac_q] : {busy_q, ac_q}) : dout_q;
        rd_data_d     = mem[rd_addr];
        if (state_q == IDLE) cnt_d = '0;
        if (state_q == OP && cnt_q == CW'(OP_CYCLES - 1)) state_d = IDLE;
        if (state_q == CLR) begin
            mem_we  = ~sweep_q[7];
            sweep_d = sweep_q + {7'd0, ~sweep_q[7]};
            if (cnt_q == CW'(CLEAR_CYCLES - 1)) state_d = IDLE;
        end
        if (rd_step) ac_d = ac_step(ac_q, entry_inc_q);
        if (wr_ok) begin
            state_d = OP;
            cnt_d   = '0;
            if (lcd_rs) begin
                mem_we        = 1'b1;
                mem_wa        = ac_q;
                mem_wd        = lcd_data_in;
                ac_d          = ac_step(ac_q, entry_inc_q);
                char_strobe_d = 1'b1;
            end else begin
                cmd_strobe_d = 1'b1;
                if (lcd_data_in[7]) ac_d = addr_ok ? lcd_data_in[6:0] : ac_q;
                else if (lcd_data_in[6:4] == 3'b000) begin
                    if (lcd_data_in[3]) {disp_on_d, cursor_on_d, blink_on_d} = lcd_data_in[2:0];
                    else if (lcd_data_in[2]) {entry_inc_d, entry_shift_d} = lcd_data_in[1:0];
                    else if (lcd_data_in[1]) ac_d = '0;
                    else if (lcd_data_in[0]) begin
                        ac_d        = '0;
                        entry_inc_d = 1'b1;
                        state_d     = CLR;
                        sweep_d     = '0;
                    end
                end
            end
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CLR;
            cnt_q         <= '0;
            sweep_q       <= '0;
            e_q           <= 1'b0;
            ac_q          <= '0;
            disp_on_q     <= 1'b0;
            cursor_on_q   <= 1'b0;
            blink_on_q    <= 1'b0;
            entry_inc_q   <= 1'b1;
            entry_shift_q <= 1'b0;
            busy_q        <= 1'b1;
            dout_q        <= '0;
            oe_q          <= 1'b0;
            cmd_strobe_q  <= 1'b0;
            char_strobe_q <= 1'b0;
            err_overrun_q <= 1'b0;
            err_addr_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sweep_q       <= sweep_d;
            e_q           <= lcd_e;
            ac_q          <= ac_d;
            disp_on_q     <= disp_on_d;
            cursor_on_q   <= cursor_on_d;
            blink_on_q    <= blink_on_d;
            entry_inc_q   <= entry_inc_d;
            entry_shift_q <= entry_shift_d;
            busy_q        <= busy_d;
            dout_q        <= dout_d;
            oe_q          <= oe_d;
            cmd_strobe_q  <= cmd_strobe_d;
            char_strobe_q <= char_strobe_d;
            err_overrun_q <= err_overrun_d;
            err_addr_q    <= err_addr_d;
            rd_data_q     <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign lcd_data_out = dout_q;
    assign lcd_data_oe  = oe_q;
    assign busy         = busy_q;
    assign cursor_addr  = ac_q;
    assign disp_on      = disp_on_q;
    assign cursor_on    = cursor_on_q;
    assign blink_on     = blink_on_q;
    assign entry_inc    = entry_inc_q;
    assign entry_shift  = entry_shift_q;
    assign cmd_strobe   = cmd_strobe_q;
    assign char_strobe  = char_strobe_q;
    assign rd_data      = rd_data_q;
    assign err_overrun  = err_overrun_q;
    assign err_addr     = err_addr_q;
endmodule

// File: tb/tb_lcd_rx_model.sv
// tb_lcd_rx_model: directed and random bus traffic against a display-level reference model.
module tb_lcd_rx_model;
    localparam int CLEAR_CYCLES = 160;
    localparam int OP_CYCLES    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lcd_data_in = '0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe, busy;
    logic [6:0] cursor_addr;
    logic       disp_on, cursor_on, blink_on, entry_inc, entry_shift;
    logic       cmd_strobe, char_strobe;
    logic [6:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       err_overrun, err_addr;
    logic       err_clr = 1'b0;

    lcd_rx_model #(.CLEAR_CYCLES(CLEAR_CYCLES), .OP_CYCLES(OP_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data_in(lcd_data_in), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe), .busy(busy),
        .cursor_addr(cursor_addr), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .entry_shift(entry_shift), .cmd_strobe(cmd_strobe),
        .char_strobe(char_strobe), .rd_addr(rd_addr), .rd_data(rd_data),
        .err_overrun(err_overrun), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: display contents, cursor, mode bits, and cycles of busy remaining.
    bit [7:0] m_mem [128];
    bit [6:0] m_ac;
    bit       m_inc, m_shift, m_disp, m_cur, m_blink, m_ovr, m_aerr;
    int       bl = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cursor motion as a position on an 80-cell ring (40 cells per line).
    function automatic bit [6:0] m_step(input bit [6:0] a, input bit inc);
        int p;
        p = (a < 7'h40) ? int'(a) : int'(a) - 64 + 40;
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bl > 0) bl--;
    endtask

    task automatic m_reset();
        m_ac = '0; m_inc = 1'b1; m_shift = 1'b0;
        m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0;
        m_ovr = 1'b0; m_aerr = 1'b0;
        foreach (m_mem[i]) m_mem[i] = 8'h20;
        bl = CLEAR_CYCLES;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".ac"}, cursor_addr, m_ac);
        chk({tag, ".busy"}, busy, bl > 0);
        chk({tag, ".err_overrun"}, err_overrun, m_ovr);
        chk({tag, ".err_addr"}, err_addr, m_aerr);
        chk({tag, ".entry"}, {entry_inc, entry_shift}, {m_inc, m_shift});
        chk({tag, ".display"}, {disp_on, cursor_on, blink_on}, {m_disp, m_cur, m_blink});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".ac"}, cursor_addr, 0);
        chk({tag, ".entry"}, {entry_inc, entry_shift}, 2'b10);
        chk({tag, ".display"}, {disp_on, cursor_on, blink_on}, 0);
        chk({tag, ".dout"}, lcd_data_out, 0);
        chk({tag, ".oe"}, lcd_data_oe, 0);
        chk({tag, ".strobes"}, {cmd_strobe, char_strobe}, 0);
        chk({tag, ".errors"}, {err_overrun, err_addr}, 0);
        chk({tag, ".rd_data"}, rd_data, 0);
    endtask

    task automatic bus_wr(input logic rs, input logic [7:0] d);
        bit bz, ec, eh;
        int a;
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_e = 1'b1;
        tick();
        lcd_e = 1'b0;
        bz = bl > 0;
        tick();
        ec = 1'b0; eh = 1'b0;
        if (bz) m_ovr = 1'b1;
        else if (rs) begin
            m_mem[m_ac] = d; m_ac = m_step(m_ac, m_inc); eh = 1'b1; bl = OP_CYCLES;
        end else begin
            ec = 1'b1; bl = OP_CYCLES;
            if (d >= 8'h80) begin
                a = int'(d) - 128;
                if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) m_ac = 7'(a);
                else m_aerr = 1'b1;
            end else if (d < 8'h10) begin
                if (d >= 8'h08) {m_disp, m_cur, m_blink} = d[2:0];
                else if (d >= 8'h04) {m_inc, m_shift} = d[1:0];
                else if (d >= 8'h02) m_ac = '0;
                else if (d == 8'h01) begin
                    m_ac = '0; m_inc = 1'b1; bl = CLEAR_CYCLES;
                    foreach (m_mem[i]) m_mem[i] = 8'h20;
                end
            end
        end
        chk("wr.cmd_strobe", cmd_strobe, ec);
        chk("wr.char_strobe", char_strobe, eh);
        chk_state("wr");
    endtask

    task automatic bus_rd(input logic rs, input string tag);
        logic [7:0] exp;
        bit bz;
        chk({tag, ".oe_before"}, lcd_data_oe, 0);
        exp = rs ? m_mem[m_ac] : {bl > 0, m_ac};
        lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
        tick();
        chk({tag, ".dout"}, lcd_data_out, exp);
        chk({tag, ".oe_rise"}, lcd_data_oe, 1);
        tick();
        chk({tag, ".oe_fallcycle"}, lcd_data_oe, 1);
        lcd_e = 1'b0;
        bz = bl > 0;
        tick();
        chk({tag, ".oe_after"}, lcd_data_oe, 0);
        if (rs && !bz) m_ac = m_step(m_ac, m_inc);
        lcd_rw = 1'b0;
        chk_state(tag);
    endtask

    task automatic host_rd(input logic [6:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick();
        chk("host_rd", rd_data, exp);
    endtask

    task automatic wait_idle();
        while (bl > 0) tick();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_ovr = 1'b0; m_aerr = 1'b0;
        chk("err_clr", {err_overrun, err_addr}, 0);
    endtask

    task automatic release_and_clear(input string tag);
        rst_n = 1'b1;
        m_reset();
        repeat (CLEAR_CYCLES - 1) tick();
        chk({tag, ".busy_last"}, busy, 1);
        tick();
        chk({tag, ".busy_done"}, busy, 0);
        chk({tag, ".ac"}, cursor_addr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int op;
        repeat (3) tick();
        chk_reset("reset");
        release_and_clear("boot");
        host_rd(7'h00, 8'h20);
        host_rd(7'h40, 8'h20);
        host_rd(7'h7F, 8'h20);

        bus_wr(0, 8'hA6);
        tick();
        chk("strobe_drop", cmd_strobe, 0);
        wait_idle();
        bus_wr(1, 8'h50); wait_idle();
        bus_wr(1, 8'h61); wait_idle();
        bus_wr(1, 8'h73); wait_idle();
        chk("pas.ac", cursor_addr, 7'h41);
        host_rd(7'h26, 8'h50);
        host_rd(7'h27, 8'h61);
        host_rd(7'h40, 8'h73);

        bus_wr(0, 8'h04); wait_idle();
        bus_wr(0, 8'h80); wait_idle();
        bus_wr(1, 8'h46); wait_idle();
        host_rd(7'h00, 8'h46);
        chk("dec.ac", cursor_addr, 7'h67);

        bus_wr(0, 8'h01);
        bus_rd(0, "stat_busy");
        chk("stat_busy.bit7", lcd_data_out[7], 1);
        bus_wr(1, 8'h46);
        chk("overrun", err_overrun, 1);
        pulse_clr();
        wait_idle();
        host_rd(7'h00, 8'h20);

        bus_wr(0, 8'hA7); wait_idle();
        bus_wr(1, 8'h61); wait_idle();
        bus_wr(0, 8'hA7); wait_idle();
        bus_rd(1, "data_rd");
        chk("data_rd.val", lcd_data_out, 8'h61);
        chk("data_rd.ac", cursor_addr, 7'h40);
        wait_idle();

        bus_wr(0, 8'hA8);
        chk("bad_addr.err", err_addr, 1);
        chk("bad_addr.ac", cursor_addr, 7'h40);
        wait_idle();
        pulse_clr();

        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 3) bus_wr(1, 8'($urandom_range(32, 126)));
            else if (op == 4) bus_wr(0, 8'h80 | 8'($urandom_range(0, 127)));
            else if (op == 5) bus_wr(0, 8'($urandom_range(2, 127)));
            else if (op == 6) bus_wr(0, 8'h04 | 8'($urandom_range(0, 3)));
            else if (op == 7) bus_rd(0, "rnd_stat");
            else if (op == 8) bus_rd(1, "rnd_data");
            else pulse_clr();
            repeat ($urandom_range(0, 5)) tick();
        end
        wait_idle();
        for (int a = 0; a < 128; a++) host_rd(7'(a), m_mem[a]);

        bus_wr(0, 8'hE0); wait_idle();
        bus_wr(1, 8'h58); wait_idle();
        host_rd(7'h60, 8'h58);
        bus_wr(0, 8'h01);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk_reset("midclr");
        release_and_clear("reboot");
        host_rd(7'h60, 8'h20);
        host_rd(7'h00, 8'h20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
